spart_tx_feeder: RTL and testbench

- Bus master that sits directly upstream of a spart instance and drives its processor-side bus (iocs/iorw/ioaddr/databus).
- After reset it programs the spart baud divisor from br_cfg.
- It then buffers bytes from a streaming producer in an internal FIFO and writes each byte to the spart transmit buffer whenever tbr reports the transmitter ready.

---
 rtl/spart_tx_feeder_if.sv | 21 ++
 rtl/spart_tx_feeder.sv | 143 ++++++++++++++
 tb/tb_spart_tx_feeder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spart_tx_feeder_if.sv
// Producer stream and spart processor-side control signals seen by the TX feeder.
// The bidirectional databus stays a plain inout port on the feeder.
interface spart_tx_feeder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       tbr;

    modport master (
        input  in_data, in_valid, tbr,
        output in_ready, iocs, iorw, ioaddr
    );

    modport slave (
        output in_data, in_valid, tbr,
        input  in_ready, iocs, iorw, ioaddr
    );
endinterface

// File: rtl/spart_tx_feeder.sv
// Programs the spart baud divisor, then drains a byte FIFO into the spart TX buffer.
//   state    | meaning
//   CFG_LO   | write divisor low byte (ioaddr 10)
//   CFG_HI   | write divisor high byte (ioaddr 11)
//   IDLE     | watch for br_cfg change, else launch a write when data and tbr
//   WRITE    | write FIFO head to TX buffer (ioaddr 00), pop
//   WAIT_TBR | give spart time to drop tbr before another write
module spart_tx_feeder #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] DIV0     = 16'h028A,
    parameter logic [15:0] DIV1     = 16'h0145,
    parameter logic [15:0] DIV2     = 16'h00A2,
    parameter logic [15:0] DIV3     = 16'h0050,
    parameter int          TBR_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               br_cfg,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     cfg_done,
    inout  wire  [7:0]               databus,
    spart_tx_feeder_if.master        bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(TBR_WAIT + 1);

    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, WRITE, WAIT_TBR} state_t;

    state_t         state, state_nx;
    logic [1:0]     cfg_latch;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [7:0]     mem [DEPTH];
    logic [WCW-1:0] wait_cnt, wait_inc;
    logic [15:0]    div_sel;
    logic           push, pop, cfg_change, wait_done;
    logic           drive, drive_q;
    logic [1:0]     addr;
    logic [7:0]     dout;

    always_comb begin
        unique case (cfg_latch)
            2'b00:   div_sel = DIV0;
            2'b01:   div_sel = DIV1;
            2'b10:   div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    assign cfg_change = (br_cfg != cfg_latch);
    assign wait_inc   = wait_cnt + 1'b1;
    assign wait_done  = (wait_inc >= WCW'(TBR_WAIT - 1));
    assign push       = bus.in_valid & bus.in_ready;
    assign pop        = (state == WRITE);

    always_comb begin
        state_nx = state;
        drive    = 1'b0;
        addr     = 2'b00;
        dout     = 8'h00;
        unique case (state)
            CFG_LO: begin
                drive    = 1'b1;
                addr     = 2'b10;
                dout     = div_sel[7:0];
                state_nx = CFG_HI;
            end
            CFG_HI: begin
                drive    = 1'b1;
                addr     = 2'b11;
                dout     = div_sel[15:8];
                state_nx = IDLE;
            end
            IDLE: begin
                if (cfg_change)
                    state_nx = CFG_LO;
                else if (count != '0 && bus.tbr)
                    state_nx = WRITE;
            end
            WRITE: begin
                drive    = 1'b1;
                addr     = 2'b00;
                dout     = mem[rd_ptr];
                state_nx = WAIT_TBR;
            end
            WAIT_TBR: begin
                if (!bus.tbr || wait_done)
                    state_nx = IDLE;
            end
            default: state_nx = CFG_LO;
        endcase
    end

    // Gating with rst lets the bus fall idle the instant reset asserts.
    assign drive_q     = drive & ~rst;
    assign bus.iocs    = drive_q;
    assign bus.iorw    = ~drive_q;
    assign bus.ioaddr  = drive_q ? addr : 2'b00;
    assign databus     = drive_q ? dout : 8'hzz;
    assign bus.in_ready = (count != CW'(DEPTH)) & ~rst;
    assign fifo_count  = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CFG_LO;
            cfg_latch <= br_cfg;
            cfg_done  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == CFG_HI)
                cfg_done <= 1'b1;
            if (state == IDLE && cfg_change) begin
                cfg_latch <= br_cfg;
                cfg_done  <= 1'b0;
            end
            if (state == WRITE)
                wait_cnt <= '0;
            else if (state == WAIT_TBR)
                wait_cnt <= wait_inc;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

endmodule

// File: tb/tb_spart_tx_feeder.sv
// Directed bench for spart_tx_feeder; every bus write is checked against a scoreboard queue.
module tb_spart_tx_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  br_cfg;
    logic [3:0]  fifo_count;
    logic        cfg_done;
    wire  [7:0]  databus;
    logic        tbr_hold = 1'b0;
    logic        tbr_pulse = 1'b1;
    logic        pulse_mode = 1'b0;
    logic        saw_write = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [9:0]  exp_q[$];
    int          stamps[$];
    logic [9:0]  mon_e;

    spart_tx_feeder_if sb();

    spart_tx_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .fifo_count (fifo_count),
        .cfg_done   (cfg_done),
        .databus    (databus),
        .bus        (sb.master)
    );

    assign sb.tbr = pulse_mode ? tbr_pulse : tbr_hold;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // spart model: tbr drops for one cycle after each TX write
    always @(negedge clk) saw_write = sb.iocs && !sb.iorw && sb.ioaddr == 2'b00;
    always @(posedge clk) begin
        #1;
        tbr_pulse = !saw_write;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (sb.iocs) begin
                chk("wr_iorw", 16'(sb.iorw), 16'h0);
                chk("sb_nonempty", 16'(exp_q.size() != 0), 16'h1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr_data", 16'({sb.ioaddr, databus}), 16'(mon_e));
                    chk("wr_cfg_done", 16'(cfg_done), 16'(sb.ioaddr == 2'b00));
                    if (sb.ioaddr == 2'b00)
                        stamps.push_back(cyc);
                end
            end else begin
                chk("idle_bus", 16'({sb.iorw, sb.ioaddr}), 16'h4);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit accept);
        sb.in_data  = b;
        sb.in_valid = 1'b1;
        if (accept)
            exp_q.push_back({2'b00, b});
        @(posedge clk);
        #1;
        sb.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_done", 16'(exp_q.size()), 16'h0);
    endtask

    task automatic wait_write();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            found = sb.iocs && sb.ioaddr == 2'b00;
        end
        chk("write_seen", 16'(found), 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        br_cfg = 2'b01;
        sb.in_valid = 1'b0;
        sb.in_data = 8'h00;
        #2;
        chk("rst_iocs", 16'(sb.iocs), 16'h0);
        chk("rst_iorw", 16'(sb.iorw), 16'h1);
        chk("rst_ioaddr", 16'(sb.ioaddr), 16'h0);
        chk("rst_in_ready", 16'(sb.in_ready), 16'h0);
        chk("rst_count", 16'(fifo_count), 16'h0);
        chk("rst_cfg_done", 16'(cfg_done), 16'h0);

        // divisor programming after release, br_cfg=01
        exp_q.push_back({2'b10, 8'h45});
        exp_q.push_back({2'b11, 8'h01});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("cfg_lo_now", 16'({sb.iocs, sb.ioaddr}), 16'h6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("cfg_done_set", 16'(cfg_done), 16'h1);
        chk("cfg_writes_seen", 16'(exp_q.size()), 16'h0);
        chk("in_ready_up", 16'(sb.in_ready), 16'h1);

        // single byte, two-cycle latency
        tbr_hold = 1'b1;
        push_byte(8'hA5, 1);
        chk("a5_count", 16'(fifo_count), 16'h1);
        chk("a5_not_yet", 16'(sb.iocs), 16'h0);
        @(posedge clk); #1;
        chk("a5_write_now", 16'({sb.iocs, sb.ioaddr}), 16'h4);
        @(posedge clk); #1;
        chk("a5_count_zero", 16'(fifo_count), 16'h0);
        tbr_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // fill to full, overflow ignored, drain with tbr pulses
        for (int i = 0; i < 8; i++)
            push_byte(8'h10 + 8'(i), 1);
        chk("full_count", 16'(fifo_count), 16'h8);
        chk("full_in_ready", 16'(sb.in_ready), 16'h0);
        push_byte(8'hEE, 0);
        chk("full_after_ovf", 16'(fifo_count), 16'h8);
        tbr_hold = 1'b1;
        pulse_mode = 1'b1;
        wait_drain(200);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_count", 16'(fifo_count), 16'h0);
        pulse_mode = 1'b0;
        tbr_hold = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // tbr stuck high: timeout path spacing
        for (int i = 0; i < 3; i++)
            push_byte(8'h30 + 8'(i), 1);
        stamps.delete();
        tbr_hold = 1'b1;
        wait_drain(100);
        chk("stamp_cnt", 16'(stamps.size()), 16'h3);
        if (stamps.size() == 3) begin
            chk("spacing_1", 16'(stamps[1] - stamps[0]), 16'h5);
            chk("spacing_2", 16'(stamps[2] - stamps[1]), 16'h5);
        end
        tbr_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // br_cfg change during WAIT_TBR
        push_byte(8'h40, 1);
        push_byte(8'h41, 1);
        tbr_hold = 1'b1;
        wait_write();
        @(posedge clk); #1;
        br_cfg = 2'b11;
        exp_q.push_front({2'b11, 8'h00});
        exp_q.push_front({2'b10, 8'h50});
        wait_drain(100);
        repeat (4) @(posedge clk);
        #1;
        chk("reconf_done", 16'(cfg_done), 16'h1);
        chk("reconf_count", 16'(fifo_count), 16'h0);
        tbr_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // reset in the middle of a WRITE
        for (int i = 0; i < 4; i++)
            push_byte(8'hC0 + 8'(i), 1);
        tbr_hold = 1'b1;
        wait_write();
        rst = 1'b1;
        #1;
        chk("mid_rst_iocs", 16'(sb.iocs), 16'h0);
        chk("mid_rst_iorw", 16'(sb.iorw), 16'h1);
        chk("mid_rst_count", 16'(fifo_count), 16'h0);
        chk("mid_rst_cfg_done", 16'(cfg_done), 16'h0);
        exp_q.delete();
        exp_q.push_back({2'b10, 8'h50});
        exp_q.push_back({2'b11, 8'h00});
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_sb", 16'(exp_q.size()), 16'h0);
        chk("post_rst_count", 16'(fifo_count), 16'h0);
        chk("post_rst_cfg_done", 16'(cfg_done), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
